// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and parameter defaults for rst_seq
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        REL       = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int LOCK_FILT_DEF   = 4;
    localparam int HOLD_CYCLES_DEF = 16;
    localparam int STAGE_GAP_DEF   = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rst_seq_filt.sv
// rtl/rst_seq_filt.sv - deglitch filter: dout follows din after LOCK_FILT consecutive differing samples
module rst_seq_filt #(
    parameter int LOCK_FILT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(LOCK_FILT) + 1;

    logic [CW-1:0] cnt;

    // Any sample matching dout restarts the run, so short glitches never reach dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(LOCK_FILT - 1)) begin
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - PLL-lock gated, staged reset release sequencer with software reset
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int LOCK_FILT   = LOCK_FILT_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int STAGE_GAP   = STAGE_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sw_rst_req,
    output logic [2:0] rst_out_n,
    output logic       ready,
    output logic       sw_ack
);

    localparam int CW = $clog2(max3(LOCK_FILT, HOLD_CYCLES, STAGE_GAP)) + 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    stage;
    logic          lock_f;

    rst_seq_filt #(
        .LOCK_FILT(LOCK_FILT)
    ) u_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pll_locked),
        .dout (lock_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            rst_out_n <= 3'b000;
            ready     <= 1'b0;
            sw_ack    <= 1'b0;
            cnt       <= '0;
            stage     <= 2'd0;
        end else begin
            sw_ack <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    if (lock_f) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (!lock_f) begin
                        state     <= WAIT_LOCK;
                        rst_out_n <= 3'b000;
                        ready     <= 1'b0;
                        cnt       <= '0;
                        stage     <= 2'd0;
                    end else if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        rst_out_n <= 3'b001;
                        state     <= REL;
                        stage     <= 2'd1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REL: begin
                    if (!lock_f) begin
                        state     <= WAIT_LOCK;
                        rst_out_n <= 3'b000;
                        ready     <= 1'b0;
                        cnt       <= '0;
                        stage     <= 2'd0;
                    end else if (cnt == CW'(STAGE_GAP - 1)) begin
                        rst_out_n <= rst_out_n | (3'b001 << stage);
                        cnt       <= '0;
                        if (stage == 2'd2) begin
                            ready <= 1'b1;
                            state <= RUN;
                            stage <= 2'd0;
                        end else begin
                            stage <= stage + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    // A request is acknowledged even when a lock loss wins the next state.
                    if (sw_rst_req) begin
                        sw_ack <= 1'b1;
                    end
                    if (!lock_f) begin
                        state     <= WAIT_LOCK;
                        rst_out_n <= 3'b000;
                        ready     <= 1'b0;
                        cnt       <= '0;
                        stage     <= 2'd0;
                    end else if (sw_rst_req) begin
                        state     <= HOLD;
                        rst_out_n <= 3'b000;
                        ready     <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: begin
                    state     <= WAIT_LOCK;
                    rst_out_n <= 3'b000;
                    ready     <= 1'b0;
                    cnt       <= '0;
                    stage     <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - self-checking bench for rst_seq against a timestamp-based reference model
module tb_rst_seq;

    localparam int LF   = 4;
    localparam int HC   = 16;
    localparam int SG   = 8;
    localparam int FULL = HC + 2 * SG;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       sw_rst_req;
    logic [2:0] rst_out_n;
    logic       ready;
    logic       sw_ack;

    int checks = 0;
    int errors = 0;

    // Reference model: lock filter as a sample window, sequencer as time since hold start
    bit m_f;
    int m_hist[$];
    bit m_act;
    int m_t;
    bit m_ack;

    int cyc;
    int first0, first1, first2, first_rdy;

    always #5 clk = ~clk;

    rst_seq #(
        .LOCK_FILT  (LF),
        .HOLD_CYCLES(HC),
        .STAGE_GAP  (SG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .sw_rst_req(sw_rst_req),
        .rst_out_n (rst_out_n),
        .ready     (ready),
        .sw_ack    (sw_ack)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_f   = 1'b0;
        m_hist.delete();
        m_act = 1'b0;
        m_t   = 0;
        m_ack = 1'b0;
    endfunction

    function automatic logic [2:0] m_out();
        if (!m_act) return 3'b000;
        return {m_t >= HC + 2 * SG, m_t >= HC + SG, m_t >= HC};
    endfunction

    function automatic void model_edge(input bit l, input bit s);
        bit fp;
        bit running;
        bit all_diff;
        if (!rst_n) begin
            m_reset();
            return;
        end
        fp      = m_f;
        running = m_act && (m_t >= FULL);
        m_ack   = 1'b0;
        if (!m_act) begin
            if (fp) begin
                m_act = 1'b1;
                m_t   = 0;
            end
        end else if (!fp) begin
            m_act = 1'b0;
            m_ack = running && s;
            m_t   = 0;
        end else if (running && s) begin
            m_ack = 1'b1;
            m_t   = 0;
        end else if (m_t < FULL) begin
            m_t++;
        end
        m_hist.push_back(int'(l));
        if (m_hist.size() > LF) void'(m_hist.pop_front());
        all_diff = (m_hist.size() == LF);
        foreach (m_hist[i]) if (m_hist[i] == int'(fp)) all_diff = 1'b0;
        if (all_diff) m_f = !fp;
    endfunction

    task automatic step(input logic l, input logic s);
        pll_locked = l;
        sw_rst_req = s;
        @(posedge clk);
        model_edge(l, s);
        #1;
        cyc++;
        if (rst_out_n[0] === 1'b1 && first0 < 0) first0 = cyc;
        if (rst_out_n[1] === 1'b1 && first1 < 0) first1 = cyc;
        if (rst_out_n[2] === 1'b1 && first2 < 0) first2 = cyc;
        if (ready === 1'b1 && first_rdy < 0) first_rdy = cyc;
        chk("outs", int'({rst_out_n, ready, sw_ack}), int'({m_out(), m_act && m_t >= FULL, m_ack}));
    endtask

    task automatic arm_timing();
        cyc       = -1;
        first0    = -1;
        first1    = -1;
        first2    = -1;
        first_rdy = -1;
    endtask

    task automatic seq_timing(input string tag);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        chk({tag, "_bit0"}, first0, HC + LF);
        chk({tag, "_bit1"}, first1, HC + LF + SG);
        chk({tag, "_bit2"}, first2, HC + LF + 2 * SG);
        chk({tag, "_ready"}, first_rdy, HC + LF + 2 * SG);
    endtask

    initial begin
        int burst;
        bit l;
        bit s;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        sw_rst_req = 1'b0;
        m_reset();
        arm_timing();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", int'({rst_out_n, ready, sw_ack}), 0);

        // Power-up sequence, lock sampled high from the first edge after release
        rst_n = 1'b1;
        arm_timing();
        seq_timing("powerup");

        // Short lock glitch in RUN is filtered out
        repeat (LF - 1) step(1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0);
        chk("glitch_rst_out", int'(rst_out_n), 7);
        chk("glitch_ready", int'(ready), 1);

        // Lock lost for LF cycles, then regained
        repeat (LF) step(1'b0, 1'b0);
        chk("lockloss_still_up", int'(rst_out_n), 7);
        arm_timing();
        step(1'b1, 1'b0);
        chk("lockloss_rst_out", int'(rst_out_n), 0);
        chk("lockloss_ready", int'(ready), 0);
        for (int i = 0; i < 39; i++) step(1'b1, 1'b0);
        chk("relock_bit0", first0, HC + LF);
        chk("relock_bit2", first2, HC + LF + 2 * SG);

        // Software reset accepted in RUN, ignored in HOLD
        arm_timing();
        step(1'b1, 1'b1);
        chk("sw_ack_pulse", int'(sw_ack), 1);
        chk("sw_rst_out", int'(rst_out_n), 0);
        step(1'b1, 1'b0);
        chk("sw_ack_one_cycle", int'(sw_ack), 0);
        repeat (3) step(1'b1, 1'b1);
        chk("sw_hold_no_ack", int'(sw_ack), 0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        chk("sw_bit0", first0, HC);
        chk("sw_ready", first_rdy, HC + 2 * SG);

        // Software reset on the same edge the sequencer sees the lock loss
        repeat (LF) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("coinc_ack", int'(sw_ack), 1);
        chk("coinc_rst_out", int'(rst_out_n), 0);
        repeat (30) step(1'b0, 1'b0);
        chk("coinc_wait_lock", int'(rst_out_n), 0);

        // Asynchronous reset while only stage 0 is released
        for (int i = 0; i < 60 && rst_out_n !== 3'b001; i++) step(1'b1, 1'b0);
        chk("reach_001", int'(rst_out_n), 1);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_rst_outs", int'({rst_out_n, ready, sw_ack}), 0);
        repeat (2) step(1'b1, 1'b0);
        #3;
        rst_n = 1'b1;
        arm_timing();
        seq_timing("after_rst");

        // Randomized lock glitches and software requests
        burst = 0;
        for (int i = 0; i < 600; i++) begin
            if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 6);
            l = (burst == 0);
            if (burst > 0) burst--;
            s = ($urandom_range(0, 14) == 0);
            step(l, s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 The parameter LOCK_FILT, default 4, SHALL be the number of consecutive cycles pll_locked must hold a new level before it is accepted.
REQ-002 The parameter HOLD_CYCLES, default 16, SHALL be the minimum all-asserted reset width in cycles.
REQ-003 The parameter STAGE_GAP, default 8, SHALL be the number of cycles between successive stage releases.
REQ-004 The port clk SHALL be an input, 1 bit, and the single clock.
REQ-005 The port rst_n SHALL be an input, 1 bit, and the reset: asynchronous, active-low, already synchronized upstream.
REQ-006 The port pll_locked SHALL be an input, 1 bit, raw PLL lock status, possibly glitchy.
REQ-007 The port sw_rst_req SHALL be an input, 1 bit, level-sampled software reset request.
REQ-008 The port rst_out_n SHALL be an output, 3 bits, per-stage active-low resets; bit 0 is released first and bit 2 last.
REQ-009 The port ready SHALL be an output, 1 bit, high only while all stages are released.
REQ-010 The port sw_ack SHALL be an output, 1 bit, a one-cycle pulse when sw_rst_req is accepted.

Function
REQ-011 The block SHALL implement the states WAIT_LOCK, HOLD, REL and RUN.
REQ-012 The filtered lock signal SHALL change only after pll_locked differs from it for LOCK_FILT consecutive cycles; a shorter glitch SHALL restart the count and cause no change.
REQ-013 In WAIT_LOCK, rst_out_n SHALL be 3'b000; a filtered lock rise SHALL move the block to HOLD with the cycle counter cleared.
REQ-014 In HOLD, rst_out_n SHALL stay 3'b000 for exactly HOLD_CYCLES cycles; on expiry, rst_out_n[0] SHALL go to 1 and the block SHALL enter REL with stage index 1.
REQ-015 In REL, every STAGE_GAP cycles the next bit rst_out_n[stage] SHALL go to 1; when bit 2 is released, ready SHALL go to 1 in the same cycle and the block SHALL enter RUN.
REQ-016 Latency SHALL be exact, counted from the first edge sampling pll_locked=1 after reset: bit 0 at LOCK_FILT+HOLD_CYCLES, bit 1 STAGE_GAP later, bit 2 and ready 2*STAGE_GAP later.
REQ-017 In RUN, sw_rst_req=1 SHALL, on the next edge, drive rst_out_n to 3'b000, ready to 0, pulse sw_ack for one cycle, and move the block to HOLD.
REQ-018 sw_rst_req SHALL be ignored, with no sw_ack, in all states other than RUN; a request held high SHALL be re-accepted only once RUN is re-entered.
REQ-019 A filtered lock fall in any state other than WAIT_LOCK SHALL, on the next edge, drive rst_out_n to 3'b000 and ready to 0, clear counters, and move the block to WAIT_LOCK.
REQ-020 A filtered lock fall coinciding with an accepted sw_rst_req SHALL send the block to WAIT_LOCK, with sw_ack still pulsing.
REQ-021 rst_out_n SHALL only transition 0->1 in ascending bit order and 1->0 on all bits simultaneously; a partial de-assertion pattern SHALL never occur.
REQ-022 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-023 Counters SHALL be sized with clog2 of the largest parameter plus 1, and SHALL never wrap.

Reset
REQ-024 When rst_n=0, asynchronously: state SHALL be WAIT_LOCK, rst_out_n SHALL be 3'b000, ready and sw_ack SHALL be 0, all counters SHALL be 0, and the filtered lock SHALL be 0.
REQ-025 An assertion of rst_n mid-sequence or in RUN SHALL immediately force the REQ-024 values, with no partial release retained.

Structure
REQ-026 The state encoding and parameter defaults SHALL reside in the shared package rst_seq_pkg.
REQ-027 The lock deglitch filter SHALL be the sub-module rst_seq_filt (inputs clk, rst_n, din; output dout; parameter LOCK_FILT).

Verification
REQ-028 Use defaults; hold pll_locked=1 from the cycle after reset is released -> rst_out_n bit0=1 at cycle 20, bit1=1 at 28, bit2=1 and ready=1 at 36.
REQ-029 Apply a 3-cycle pll_locked low glitch in RUN -> no output change.
REQ-030 Hold pll_locked low for 4 cycles in RUN -> rst_out_n=000 and ready=0 the next edge; after lock returns, the full sequence repeats with REQ-028 timing.
REQ-031 Pulse sw_rst_req in RUN -> sw_ack high for 1 cycle, rst_out_n=000, and bit0 re-released 16 cycles later; sw_rst_req during HOLD -> no sw_ack.
REQ-032 Assert sw_rst_req and a lock loss, with the filter expiring on the same edge -> sw_ack pulses and the state is WAIT_LOCK.
REQ-033 Assert rst_n=0 while rst_out_n=001 -> all outputs are 0 asynchronously, and the sequence restarts cleanly after rst_n returns high.
